wb_trigger_mux: RTL and testbench
=================================

WB_TRIGGER_MUX -- requirements
Module: wb_trigger_mux

Interface
REQ-001 SHALL have parameter NCH, default 4, number of filter channels (1..16).
REQ-002 SHALL have parameter NSTAGE, default 16, filter stages per channel (2..16).
REQ-003 SHALL have parameter CW, default 16, width of window, width and deadtime counters.
REQ-004 SHALL have port clkf_i, input, 1, the single filter clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port sd_i, input, NCH*NSTAGE, stage outputs; channel c stage s is bit c*NSTAGE+s.
REQ-007 SHALL have port stage_sel_i, input, NCH*4, per-channel stage select; channel c uses bits 4c+3:4c.
REQ-008 SHALL have port chan_en_i, input, NCH, per-channel enable mask.
REQ-009 SHALL have port mode_i, input, 2: 0=OR, 1=AND, 2=MAJORITY, 3=reserved (behaves as OR).
REQ-010 SHALL have port thresh_i, input, 5, majority threshold.
REQ-011 SHALL have port coinc_win_i, input, CW, coincidence window in cycles.
REQ-012 SHALL have port width_i, input, CW, trigger pulse width in cycles.
REQ-013 SHALL have port dead_i, input, CW, deadtime in cycles after the pulse.
REQ-014 SHALL have port trigger_o, output, 1, registered trigger pulse.
REQ-015 SHALL have port hit_o, output, NCH, channel pattern captured at trigger.
REQ-016 SHALL have port busy_o, output, 1, high in FIRE or DEAD.

Function
REQ-017 Per channel SHALL register the selected stage bit, then detect its rising edge (previous 0, current 1).
REQ-018 A stage_sel value >= NSTAGE SHALL make that channel permanently inactive.
REQ-019 A rising edge SHALL load the channel window counter with coinc_win_i.
- Channel is active on the edge cycle and while its counter is non-zero.
- A new edge reloads the counter (retrigger).
- coinc_win_i=0: active on the edge cycle only.
REQ-020 Condition:
- OR: any enabled channel active.
- AND: all enabled channels active; mask all-zero never fires.
- MAJORITY: popcount(active & en) >= thresh_i; thresh_i=0 is treated as 1.
REQ-021 FSM states IDLE, FIRE, DEAD:
- IDLE -> FIRE when the condition holds.
- FIRE -> DEAD after max(width_i,1) cycles.
- DEAD -> IDLE after dead_i cycles; dead_i=0 goes from FIRE directly to IDLE.
REQ-022 width_i and dead_i SHALL be latched at FIRE entry; later changes affect the next trigger only.
REQ-023 trigger_o SHALL be high exactly during FIRE.
REQ-024 Latency SHALL be 3 cycles: stage bit first sampled high at edge N gives trigger_o high from edge N+3.
REQ-025 At FIRE entry: hit_o SHALL capture active&en; all window counters SHALL clear.
- Edges arriving during FIRE/DEAD SHALL still open windows.
- The condition is ignored until IDLE.
REQ-026 A condition true on the cycle DEAD returns to IDLE SHALL fire on the next cycle.

Reset
REQ-027 When rst_i is high at a clock edge:
- FSM -> IDLE; trigger_o, busy_o, hit_o -> 0.
- Edge registers and window counters -> 0.
- Applies mid-pulse or mid-deadtime.
REQ-028 A stage bit already high when reset is released SHALL NOT count as a rising edge.

Configuration
REQ-029 Macro WB_TRIGGER_COUNT_EN, when defined, SHALL add:
- input count_clr_i, 1.
- output trig_count_o, 32, counts FIRE entries, saturates at 2^32-1.
- Reset and count_clr_i both clear it; clear wins over a simultaneous increment.
REQ-030 Without WB_TRIGGER_COUNT_EN, those ports and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package wb_trigger_pkg SHALL hold the mode encodings, FSM state encodings and the 32-bit count width constant.
REQ-032 Sub-module wb_trigger_chan SHALL hold one channel (stage mux, sync register, edge detect, window counter), instantiated NCH times.
REQ-033 trigger_o SHALL drive the SB_GB global buffer at the parent level, not inside this block.

Verification
REQ-034 OR, en=0001, sel0=3, width=4, dead=10: ch0 stage3 rises at edge N -> trigger_o high at N+3..N+6, busy_o through N+16, hit_o=0001.
REQ-035 AND, en=0011, win=5: ch1 edge 4 cycles after ch0 -> fires, hit_o=0011; at 6 cycles apart -> no trigger.
REQ-036 MAJORITY, thresh=3, en=1111: two concurrent channel edges -> none; three -> fires; thresh=0 with one edge -> fires.
REQ-037 Edge during DEAD with win=20, dead=5: no trigger in DEAD; fires on the cycle after DEAD exits while the window is still open.
REQ-038 rst_i pulsed in FIRE -> trigger_o 0 next cycle; held-high stage bit after release gives no trigger.
REQ-039 With WB_TRIGGER_COUNT_EN: 3 triggers -> trig_count_o=3; count_clr_i coincident with a FIRE entry -> 0.

Source files
------------

// File: rtl/wb_trigger_pkg.sv
// Shared encodings for the trigger multiplexer: condition modes, FSM states
// and the trigger counter width.
package wb_trigger_pkg;

  typedef enum logic [1:0] {
    MODE_OR   = 2'd0,
    MODE_AND  = 2'd1,
    MODE_MAJ  = 2'd2,
    MODE_RSVD = 2'd3
  } trig_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_DEAD = 2'd2
  } trig_state_e;

  localparam int COUNT_W = 32;

endpackage

// File: rtl/wb_trigger_chan.sv
// One trigger channel: stage mux, sync register, rising-edge detect and
// coincidence window; the registered active flag feeds the trigger condition.
module wb_trigger_chan
  import wb_trigger_pkg::*;
#(
  parameter int NSTAGE = 16,
  parameter int CW     = 16
) (
  input  logic              clkf_i,
  input  logic              rst_i,
  input  logic [NSTAGE-1:0] sd,
  input  logic [3:0]        sel,
  input  logic [CW-1:0]     win,
  input  logic              clr,
  output logic              active
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [15:0]   stage_pad;
  logic          sync_q;
  logic          prev_q;
  logic          sync_vld_q;
  logic          prev_vld_q;
  logic          rise_q;
  logic [CW-1:0] win_cnt;

  // Zero padding makes any select at or beyond NSTAGE read a constant 0.
  assign stage_pad = 16'(sd);

  // prev_vld_q blocks an edge until prev_q holds a real post-reset sample,
  // so a stage already high when reset drops is not seen as a rising edge.
  always_ff @(posedge clkf_i) begin
    if (rst_i) begin
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      sync_vld_q <= 1'b0;
      prev_vld_q <= 1'b0;
      rise_q     <= 1'b0;
      win_cnt    <= '0;
      active     <= 1'b0;
    end else begin
      sync_q     <= stage_pad[sel];
      prev_q     <= sync_q;
      sync_vld_q <= 1'b1;
      prev_vld_q <= sync_vld_q;
      rise_q     <= sync_q & ~prev_q & prev_vld_q;
      if (clr) begin
        win_cnt <= '0;
        active  <= 1'b0;
      end else begin
        if (rise_q)
          win_cnt <= win;
        else if (win_cnt != '0)
          win_cnt <= win_cnt - ONE;
        active <= rise_q | (win_cnt != '0);
      end
    end
  end

endmodule

// File: rtl/wb_trigger_mux.sv
// Trigger multiplexer: combines NCH filtered channels into a pulse with deadtime.
// Optional WB_TRIGGER_COUNT_EN adds a saturating trigger counter; trigger_o is buffered by the parent.
module wb_trigger_mux
  import wb_trigger_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int NSTAGE = 16,
  parameter int CW     = 16
) (
  input  logic                  clkf_i,
  input  logic                  rst_i,
  input  logic [NCH*NSTAGE-1:0] sd_i,
  input  logic [NCH*4-1:0]      stage_sel_i,
  input  logic [NCH-1:0]        chan_en_i,
  input  logic [1:0]            mode_i,
  input  logic [4:0]            thresh_i,
  input  logic [CW-1:0]         coinc_win_i,
  input  logic [CW-1:0]         width_i,
  input  logic [CW-1:0]         dead_i,
  output logic                  trigger_o,
  output logic [NCH-1:0]        hit_o,
  output logic                  busy_o
`ifdef WB_TRIGGER_COUNT_EN
  ,
  input  logic                  count_clr_i,
  output logic [COUNT_W-1:0]    trig_count_o
`endif
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [NCH-1:0] act;
  logic [NCH-1:0] act_en;
  logic [4:0]     pop;
  logic [4:0]     thr;
  logic           cond;
  logic           fire_entry;
  trig_state_e    state;
  logic [CW-1:0]  tcnt;
  logic [CW-1:0]  dead_l;

  for (genvar c = 0; c < NCH; c++) begin : gen_chan
    wb_trigger_chan #(
      .NSTAGE(NSTAGE),
      .CW    (CW)
    ) u_chan (
      .clkf_i(clkf_i),
      .rst_i (rst_i),
      .sd    (sd_i[c*NSTAGE +: NSTAGE]),
      .sel   (stage_sel_i[4*c +: 4]),
      .win   (coinc_win_i),
      .clr   (fire_entry),
      .active(act[c])
    );
  end

  assign act_en = act & chan_en_i;

  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++)
      pop = pop + 5'(act_en[c]);
    thr  = (thresh_i == '0) ? 5'd1 : thresh_i;
    cond = 1'b0;
    case (trig_mode_e'(mode_i))
      MODE_AND: cond = (chan_en_i != '0) && (act_en == chan_en_i);
      MODE_MAJ: cond = (pop >= thr);
      default:  cond = |act_en;
    endcase
    fire_entry = (state == ST_IDLE) && cond;
  end

  // Pulse width is loaded into tcnt at entry and deadtime is held in dead_l,
  // so input changes mid-pulse only shape the next trigger.
  always_ff @(posedge clkf_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      trigger_o <= 1'b0;
      busy_o    <= 1'b0;
      hit_o     <= '0;
      tcnt      <= '0;
      dead_l    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cond) begin
            state     <= ST_FIRE;
            trigger_o <= 1'b1;
            busy_o    <= 1'b1;
            hit_o     <= act_en;
            tcnt      <= (width_i == '0) ? '0 : width_i - ONE;
            dead_l    <= dead_i;
          end
        end
        ST_FIRE: begin
          if (tcnt == '0) begin
            trigger_o <= 1'b0;
            if (dead_l == '0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_DEAD;
              tcnt  <= dead_l - ONE;
            end
          end else begin
            tcnt <= tcnt - ONE;
          end
        end
        ST_DEAD: begin
          if (tcnt == '0) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            tcnt <= tcnt - ONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          trigger_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_TRIGGER_COUNT_EN
  always_ff @(posedge clkf_i) begin
    if (rst_i || count_clr_i)
      trig_count_o <= '0;
    else if (fire_entry && (trig_count_o != '1))
      trig_count_o <= trig_count_o + COUNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_wb_trigger_mux.sv
// Directed self-checking bench for wb_trigger_mux; also covers the
// WB_TRIGGER_COUNT_EN counter when that macro is defined.
module tb_wb_trigger_mux;
  import wb_trigger_pkg::*;

  localparam int NCH    = 4;
  localparam int NSTAGE = 16;
  localparam int CW     = 16;

  logic                  clkf_i = 1'b0;
  logic                  rst_i;
  logic [NCH*NSTAGE-1:0] sd_i;
  logic [NCH*4-1:0]      stage_sel_i;
  logic [NCH-1:0]        chan_en_i;
  logic [1:0]            mode_i;
  logic [4:0]            thresh_i;
  logic [CW-1:0]         coinc_win_i;
  logic [CW-1:0]         width_i;
  logic [CW-1:0]         dead_i;
  logic                  trigger_o;
  logic [NCH-1:0]        hit_o;
  logic                  busy_o;
`ifdef WB_TRIGGER_COUNT_EN
  logic                  count_clr_i;
  logic [COUNT_W-1:0]    trig_count_o;
`endif

  int   total = 0;
  int   bad   = 0;
  int   fires = 0;
  int   base  = 0;
  logic trig_q = 1'b0;

  wb_trigger_mux #(
    .NCH   (NCH),
    .NSTAGE(NSTAGE),
    .CW    (CW)
  ) dut (
    .clkf_i      (clkf_i),
    .rst_i       (rst_i),
    .sd_i        (sd_i),
    .stage_sel_i (stage_sel_i),
    .chan_en_i   (chan_en_i),
    .mode_i      (mode_i),
    .thresh_i    (thresh_i),
    .coinc_win_i (coinc_win_i),
    .width_i     (width_i),
    .dead_i      (dead_i),
    .trigger_o   (trigger_o),
    .hit_o       (hit_o),
    .busy_o      (busy_o)
`ifdef WB_TRIGGER_COUNT_EN
    ,
    .count_clr_i (count_clr_i),
    .trig_count_o(trig_count_o)
`endif
  );

  always #5 clkf_i = ~clkf_i;

  // Counts trigger pulses so single-cycle pulses between checkpoints are not missed.
  always @(negedge clkf_i) begin
    if (trigger_o && !trig_q)
      fires++;
    trig_q = trigger_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkf_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] en,
                               input logic [4:0] thr, input logic [15:0] win,
                               input logic [15:0] width, input logic [15:0] dead);
    mode_i      = mode;
    chan_en_i   = en;
    thresh_i    = thr;
    coinc_win_i = win;
    width_i     = width;
    dead_i      = dead;
  endtask

  task automatic set_bit(input int c, input int s, input logic v);
    sd_i[c*NSTAGE+s] = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    sd_i        = '0;
    stage_sel_i = 16'h3333;
`ifdef WB_TRIGGER_COUNT_EN
    count_clr_i = 1'b0;
`endif
    applyStimulus(2'd0, 4'b0000, 5'd0, 16'd0, 16'd0, 16'd0);
    step(3);
    checkOutput("rst_trig", 32'(trigger_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_hit", 32'(hit_o), 32'd0);
    rst_i = 1'b0;
    step(3);

    // OR, basic latency/width/deadtime; width/dead changed mid-pulse
    applyStimulus(2'd0, 4'b0001, 5'd0, 16'd0, 16'd4, 16'd10);
    set_bit(0, 3, 1'b1);
    step(3);
    checkOutput("or_lat_n2", 32'(trigger_o), 32'd0);
    step(1);
    checkOutput("or_fire_n3", 32'(trigger_o), 32'd1);
    checkOutput("or_hit", 32'(hit_o), 32'h1);
    checkOutput("or_busy_n3", 32'(busy_o), 32'd1);
    applyStimulus(2'd0, 4'b0001, 5'd0, 16'd0, 16'd1, 16'd0);
    step(3);
    checkOutput("or_fire_n6", 32'(trigger_o), 32'd1);
    step(1);
    checkOutput("or_trig_n7", 32'(trigger_o), 32'd0);
    checkOutput("or_busy_n7", 32'(busy_o), 32'd1);
    step(9);
    checkOutput("or_busy_n16", 32'(busy_o), 32'd1);
    step(1);
    checkOutput("or_busy_n17", 32'(busy_o), 32'd0);
    set_bit(0, 3, 1'b0);
    step(4);

    // AND, coincidence window 5
    applyStimulus(2'd1, 4'b0011, 5'd0, 16'd5, 16'd1, 16'd0);
    set_bit(0, 3, 1'b1);
    step(4);
    set_bit(1, 3, 1'b1);
    step(3);
    checkOutput("and4_n6", 32'(trigger_o), 32'd0);
    step(1);
    checkOutput("and4_fire", 32'(trigger_o), 32'd1);
    checkOutput("and4_hit", 32'(hit_o), 32'h3);
    step(1);
    checkOutput("and4_end", 32'(trigger_o), 32'd0);
    checkOutput("and4_busy", 32'(busy_o), 32'd0);
    set_bit(0, 3, 1'b0);
    set_bit(1, 3, 1'b0);
    step(10);
    base = fires;
    set_bit(0, 3, 1'b1);
    step(6);
    set_bit(1, 3, 1'b1);
    step(12);
    checkOutput("and_6apart", 32'(fires - base), 32'd0);
    set_bit(0, 3, 1'b0);
    set_bit(1, 3, 1'b0);
    step(10);
    base = fires;
    set_bit(0, 3, 1'b1);
    step(5);
    set_bit(1, 3, 1'b1);
    step(12);
    checkOutput("and_5apart", 32'(fires - base), 32'd1);
    set_bit(0, 3, 1'b0);
    set_bit(1, 3, 1'b0);
    step(10);

    // MAJORITY, threshold 3 then threshold 0
    applyStimulus(2'd2, 4'b1111, 5'd3, 16'd3, 16'd1, 16'd0);
    base = fires;
    set_bit(0, 3, 1'b1);
    set_bit(1, 3, 1'b1);
    step(10);
    checkOutput("maj_two", 32'(fires - base), 32'd0);
    set_bit(0, 3, 1'b0);
    set_bit(1, 3, 1'b0);
    step(8);
    set_bit(0, 3, 1'b1);
    set_bit(1, 3, 1'b1);
    set_bit(2, 3, 1'b1);
    step(4);
    checkOutput("maj_three", 32'(trigger_o), 32'd1);
    checkOutput("maj_three_hit", 32'(hit_o), 32'h7);
    step(4);
    set_bit(0, 3, 1'b0);
    set_bit(1, 3, 1'b0);
    set_bit(2, 3, 1'b0);
    step(8);
    applyStimulus(2'd2, 4'b1111, 5'd0, 16'd3, 16'd1, 16'd0);
    set_bit(3, 3, 1'b1);
    step(4);
    checkOutput("maj_thr0", 32'(trigger_o), 32'd1);
    checkOutput("maj_thr0_hit", 32'(hit_o), 32'h8);
    step(4);
    set_bit(3, 3, 1'b0);
    step(8);

    // Edge arriving during DEAD fires right after DEAD ends
    applyStimulus(2'd0, 4'b0011, 5'd0, 16'd20, 16'd2, 16'd5);
    set_bit(0, 3, 1'b1);
    step(4);
    checkOutput("dead_first", 32'(trigger_o), 32'd1);
    step(2);
    checkOutput("dead_enter_trig", 32'(trigger_o), 32'd0);
    checkOutput("dead_enter_busy", 32'(busy_o), 32'd1);
    set_bit(1, 3, 1'b1);
    step(4);
    checkOutput("dead_hold_trig", 32'(trigger_o), 32'd0);
    checkOutput("dead_hold_busy", 32'(busy_o), 32'd1);
    step(1);
    checkOutput("dead_exit_trig", 32'(trigger_o), 32'd0);
    checkOutput("dead_exit_busy", 32'(busy_o), 32'd0);
    step(1);
    checkOutput("dead_refire", 32'(trigger_o), 32'd1);
    checkOutput("dead_refire_hit", 32'(hit_o), 32'h2);
    step(12);
    set_bit(0, 3, 1'b0);
    set_bit(1, 3, 1'b0);
    step(6);

    // Stage select picks only the addressed stage
    stage_sel_i = 16'h3335;
    applyStimulus(2'd0, 4'b0001, 5'd0, 16'd0, 16'd1, 16'd0);
    base = fires;
    set_bit(0, 3, 1'b1);
    step(8);
    checkOutput("sel_other", 32'(fires - base), 32'd0);
    set_bit(0, 5, 1'b1);
    step(4);
    checkOutput("sel_match", 32'(trigger_o), 32'd1);
    step(4);
    set_bit(0, 3, 1'b0);
    set_bit(0, 5, 1'b0);
    stage_sel_i = 16'h3333;
    step(4);

    // Reset mid-pulse, stage bit held high across release
    applyStimulus(2'd0, 4'b0001, 5'd0, 16'd0, 16'd8, 16'd3);
    set_bit(0, 3, 1'b1);
    step(4);
    checkOutput("rstp_fire", 32'(trigger_o), 32'd1);
    step(1);
    rst_i = 1'b1;
    step(1);
    checkOutput("rstp_trig", 32'(trigger_o), 32'd0);
    checkOutput("rstp_busy", 32'(busy_o), 32'd0);
    checkOutput("rstp_hit", 32'(hit_o), 32'd0);
    rst_i = 1'b0;
    base = fires;
    step(12);
    checkOutput("rstp_held", 32'(fires - base), 32'd0);
    checkOutput("rstp_idle", 32'(trigger_o), 32'd0);
    set_bit(0, 3, 1'b0);
    step(4);

`ifdef WB_TRIGGER_COUNT_EN
    checkOutput("cnt_rst", trig_count_o, 32'd0);
    applyStimulus(2'd0, 4'b0001, 5'd0, 16'd0, 16'd1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      set_bit(0, 3, 1'b1);
      step(4);
      set_bit(0, 3, 1'b0);
      step(4);
    end
    checkOutput("cnt_three", trig_count_o, 32'd3);
    set_bit(0, 3, 1'b1);
    step(3);
    count_clr_i = 1'b1;
    step(1);
    checkOutput("cnt_clr_fire", 32'(trigger_o), 32'd1);
    checkOutput("cnt_clr_wins", trig_count_o, 32'd0);
    count_clr_i = 1'b0;
    step(3);
    checkOutput("cnt_clr_hold", trig_count_o, 32'd0);
    set_bit(0, 3, 1'b0);
    step(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
